// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared encodings for the LCD message pager
package lcd_pkg;

   localparam int LCD_DATA_W = 18;

   localparam logic [1:0] MODE_AUTO   = 2'b00;
   localparam logic [1:0] MODE_MANUAL = 2'b01;
   localparam logic [1:0] MODE_HOLD   = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SEND  = 2'd2,
      ST_DWELL = 2'd3
   } state_t;

endpackage

// File: rtl/lcd_tick_counter.sv
// rtl/lcd_tick_counter.sv - saturating tick counter with clear and terminal count
module lcd_tick_counter #(
   parameter int TICKS = 8,
   localparam int CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TICKS - 1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_count <= '0;
      end else if (i_en && (r_count != LP_LAST)) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_tc = (r_count == LP_LAST);

endmodule

// File: rtl/lcd_msg_sequencer.sv
// rtl/lcd_msg_sequencer.sv - message slot table paged to the LCD driver over valid/ready
module lcd_msg_sequencer
   import lcd_pkg::*;
#(
   parameter int DATA_W      = LCD_DATA_W,
   parameter int NUM_MSG     = 4,
   parameter int DWELL_TICKS = 50_000_000,
   localparam int IDX_W      = $clog2(NUM_MSG)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wr_en,
   input  logic [IDX_W-1:0]  i_wr_idx,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [1:0]        i_mode,
   input  logic              i_step,
   output logic [DATA_W-1:0] o_msg_data,
   output logic [IDX_W-1:0]  o_msg_idx,
   output logic              o_msg_valid,
   input  logic              i_msg_ready,
   output logic [9:0]        o_leds
);

   localparam logic [IDX_W:0]   LP_NUM_MSG  = (IDX_W + 1)'(NUM_MSG);
   localparam logic [IDX_W-1:0] LP_LAST_IDX = IDX_W'(NUM_MSG - 1);

   state_t            r_state;
   logic [DATA_W-1:0] r_slot [NUM_MSG];
   logic [DATA_W-1:0] r_msg_data;
   logic [IDX_W-1:0]  r_msg_idx;
   logic [IDX_W-1:0]  r_cur_idx;
   logic              r_msg_valid;
   logic              r_step_q;
   logic              r_pending;
   logic              r_heartbeat;

   logic w_wr_ok;
   logic w_rise;
   logic w_accept;
   logic w_resend;
   logic w_advance;
   logic w_consume;
   logic w_dwell_tc;
   logic [9:0] w_leds;

   assign w_wr_ok  = i_wr_en && ({1'b0, i_wr_idx} < LP_NUM_MSG);
   assign w_rise   = i_step & ~r_step_q;
   assign w_accept = (r_state == ST_SEND) && r_msg_valid && i_msg_ready;
   assign w_resend = (r_state == ST_DWELL) && w_wr_ok && (i_wr_idx == r_cur_idx);

   always_comb begin
      w_advance = 1'b0;
      w_consume = 1'b0;
      case (i_mode)
         MODE_AUTO:   w_advance = w_dwell_tc;
         MODE_MANUAL: begin
            w_advance = r_pending;
            w_consume = r_pending;
         end
         MODE_HOLD:   w_advance = 1'b0;
         default:     w_advance = 1'b0;
      endcase
   end

   lcd_tick_counter #(
      .TICKS (DWELL_TICKS)
   ) u_dwell (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_clr (w_accept),
      .i_en  (r_state == ST_DWELL),
      .o_tc  (w_dwell_tc)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_msg_data  <= '0;
         r_msg_idx   <= '0;
         r_cur_idx   <= '0;
         r_msg_valid <= 1'b0;
         r_step_q    <= 1'b0;
         r_pending   <= 1'b0;
         r_heartbeat <= 1'b0;
         for (int i = 0; i < NUM_MSG; i++) begin
            r_slot[i] <= '0;
         end
      end else begin
         r_step_q <= i_step;
         if (w_wr_ok) begin
            r_slot[i_wr_idx] <= i_wr_data;
         end

         case (r_state)
            ST_IDLE: r_state <= ST_LOAD;
            ST_LOAD: begin
               r_msg_data  <= r_slot[r_cur_idx];
               r_msg_idx   <= r_cur_idx;
               r_msg_valid <= 1'b1;
               r_state     <= ST_SEND;
            end
            ST_SEND: begin
               if (w_accept) begin
                  r_msg_valid <= 1'b0;
                  r_state     <= ST_DWELL;
               end
            end
            ST_DWELL: begin
               // a rewrite of the shown slot wins over advancing; any pending step survives it
               if (w_resend) begin
                  r_state <= ST_LOAD;
               end else if (w_advance) begin
                  r_cur_idx <= (r_cur_idx == LP_LAST_IDX) ? '0 : r_cur_idx + 1'b1;
                  r_state   <= ST_LOAD;
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         if ((r_state == ST_DWELL) && !w_resend && w_consume) begin
            r_pending <= 1'b0;
         end else if (w_rise && (i_mode == MODE_MANUAL)) begin
            r_pending <= 1'b1;
         end

         if ((r_state == ST_DWELL) && (i_mode == MODE_AUTO) && w_dwell_tc) begin
            r_heartbeat <= ~r_heartbeat;
         end
      end
   end

   always_comb begin
      w_leds             = '0;
      w_leds[IDX_W-1:0]  = r_msg_idx;
      w_leds[8]          = r_heartbeat;
      w_leds[9]          = r_msg_valid;
   end

   assign o_msg_data  = r_msg_data;
   assign o_msg_idx   = r_msg_idx;
   assign o_msg_valid = r_msg_valid;
   assign o_leds      = w_leds;

endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// tb/tb_lcd_msg_sequencer.sv - directed self-checking bench for lcd_msg_sequencer
module tb_lcd_msg_sequencer;
   import lcd_pkg::*;

   typedef struct {
      int          cyc;
      logic [1:0]  idx;
      logic [17:0] data;
      logic [9:0]  leds;
   } acc_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [1:0]  wr_idx;
   logic [17:0] wr_data;
   logic [1:0]  mode;
   logic        step;
   logic        ready;
   logic [17:0] o_msg_data;
   logic [1:0]  o_msg_idx;
   logic        o_msg_valid;
   logic [9:0]  o_leds;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   acc_t acc_q[$];
   acc_t mon_e;
   logic [17:0] slot_init [4] = '{18'h0_1C70, 18'h3_8E39, 18'h0_71C2, 18'h3_8E3B};

   lcd_msg_sequencer #(
      .DATA_W      (18),
      .NUM_MSG     (4),
      .DWELL_TICKS (8)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_wr_en     (wr_en),
      .i_wr_idx    (wr_idx),
      .i_wr_data   (wr_data),
      .i_mode      (mode),
      .i_step      (step),
      .o_msg_data  (o_msg_data),
      .o_msg_idx   (o_msg_idx),
      .o_msg_valid (o_msg_valid),
      .i_msg_ready (ready),
      .o_leds      (o_leds)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst && o_msg_valid && ready) begin
         mon_e.cyc  = cyc;
         mon_e.idx  = o_msg_idx;
         mon_e.data = o_msg_data;
         mon_e.leds = o_leds;
         acc_q.push_back(mon_e);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_accept(input int target, input int limit, output bit ok);
      int k = 0;
      while (acc_q.size() < target && k < limit) begin
         tick();
         k++;
      end
      ok = (acc_q.size() >= target);
   endtask

   task automatic wait_valid(input int limit, output bit ok);
      int k = 0;
      while (o_msg_valid !== 1'b1 && k < limit) begin
         tick();
         k++;
      end
      ok = (o_msg_valid === 1'b1);
   endtask

   task automatic pulse_step();
      step = 1'b1;
      tick();
      step = 1'b0;
      tick();
   endtask

   task automatic step_accept(output bit ok);
      int n = acc_q.size();
      pulse_step();
      wait_accept(n + 1, 30, ok);
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_en = 1'b0; wr_idx = 2'd0; wr_data = '0;
      mode = MODE_AUTO; step = 1'b0; ready = 1'b1;
      tick();
      tick();
      checks++;
      if (o_msg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_msg_valid); end
      checks++;
      if (o_msg_idx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", o_msg_idx); end
      checks++;
      if (o_msg_data !== 18'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", o_msg_data); end
      checks++;
      if (o_leds !== 10'h0) begin errors++; $display("FAIL reset_leds: got %h expected 0", o_leds); end
      rst = 1'b0;
   endtask

   task automatic test_auto_rotate();
      bit ok;
      logic [9:0] exp_l;
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_idx = 2'(i); wr_data = slot_init[i];
         tick();
         if (i == 0) begin
            checks++;
            if (o_msg_valid !== 1'b0) begin errors++; $display("FAIL first_valid_early: got %b expected 0", o_msg_valid); end
         end
         if (i == 1) begin
            checks++;
            if ({o_msg_valid, o_msg_idx, o_msg_data} !== {1'b1, 2'd0, slot_init[0]})
               begin errors++; $display("FAIL first_send: got %b/%0d/%h expected 1/0/%h", o_msg_valid, o_msg_idx, o_msg_data, slot_init[0]); end
         end
      end
      wr_en = 1'b0;
      wait_accept(5, 100, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL auto_timeout: got %0d acceptances expected 5", acc_q.size()); end
      else begin
         for (int k = 0; k < 5; k++) begin
            exp_l = '0;
            exp_l[9] = 1'b1;
            exp_l[8] = ((k % 2) == 1);
            exp_l[1:0] = 2'(k % 4);
            checks++;
            if (acc_q[k].idx !== 2'(k % 4) || acc_q[k].data !== slot_init[k % 4])
               begin errors++; $display("FAIL auto_msg%0d: got %0d/%h expected %0d/%h", k, acc_q[k].idx, acc_q[k].data, k % 4, slot_init[k % 4]); end
            checks++;
            if (acc_q[k].leds !== exp_l)
               begin errors++; $display("FAIL auto_leds%0d: got %h expected %h", k, acc_q[k].leds, exp_l); end
            if (k > 0) begin
               checks++;
               if (acc_q[k].cyc - acc_q[k-1].cyc != 10)
                  begin errors++; $display("FAIL auto_interval%0d: got %0d expected 10", k, acc_q[k].cyc - acc_q[k-1].cyc); end
            end
         end
      end
   endtask

   task automatic test_ready_stall();
      bit ok;
      int n;
      logic [17:0] held_d;
      ready = 1'b0;
      wait_valid(30, ok);
      held_d = o_msg_data;
      checks++;
      if (!ok || o_msg_idx !== 2'd1 || held_d !== slot_init[1])
         begin errors++; $display("FAIL stall_start: got %b/%0d/%h expected 1/1/%h", ok, o_msg_idx, held_d, slot_init[1]); end
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if ({o_msg_valid, o_msg_data} !== {1'b1, slot_init[1]})
            begin errors++; $display("FAIL stall_hold%0d: got %b/%h expected 1/%h", i, o_msg_valid, o_msg_data, slot_init[1]); end
      end
      n = acc_q.size();
      ready = 1'b1;
      tick();
      checks++;
      if (acc_q.size() != n + 1) begin errors++; $display("FAIL stall_accept: got %0d acceptances expected %0d", acc_q.size(), n + 1); end
      else if (acc_q[n].idx !== 2'd1) begin errors++; $display("FAIL stall_accept: got idx %0d expected 1", acc_q[n].idx); end
      checks++;
      if (o_msg_valid !== 1'b0) begin errors++; $display("FAIL stall_drop: got %b expected 0", o_msg_valid); end
   endtask

   task automatic test_manual_step();
      bit ok;
      int n;
      mode = MODE_MANUAL;
      ready = 1'b0;
      pulse_step();
      wait_valid(20, ok);
      checks++;
      if (!ok || o_msg_idx !== 2'd2 || o_msg_data !== slot_init[2])
         begin errors++; $display("FAIL manual_first: got %b/%0d/%h expected 1/2/%h", ok, o_msg_idx, o_msg_data, slot_init[2]); end
      pulse_step();
      pulse_step();
      n = acc_q.size();
      ready = 1'b1;
      wait_accept(n + 2, 40, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL manual_timeout: got %0d acceptances expected %0d", acc_q.size(), n + 2); end
      else if (acc_q[n].idx !== 2'd2 || acc_q[n+1].idx !== 2'd3)
         begin errors++; $display("FAIL manual_order: got %0d,%0d expected 2,3", acc_q[n].idx, acc_q[n+1].idx); end
      repeat (30) tick();
      checks++;
      if (acc_q.size() != n + 2) begin errors++; $display("FAIL manual_single: got %0d acceptances expected %0d", acc_q.size(), n + 2); end
   endtask

   task automatic test_hold_resend();
      bit ok;
      int n;
      for (int j = 0; j < 3; j++) begin
         step_accept(ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL hold_walk%0d: got no acceptance expected one", j); end
      end
      checks++;
      if (acc_q[acc_q.size()-1].idx !== 2'd2) begin errors++; $display("FAIL hold_walk_idx: got %0d expected 2", acc_q[acc_q.size()-1].idx); end
      mode = MODE_HOLD;
      n = acc_q.size();
      repeat (20) tick();
      checks++;
      if (acc_q.size() != n) begin errors++; $display("FAIL hold_idle: got %0d acceptances expected %0d", acc_q.size(), n); end
      wr_en = 1'b1; wr_idx = 2'd2; wr_data = 18'h2_AAAA;
      tick();
      wr_en = 1'b0;
      wait_accept(n + 1, 20, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL hold_resend: got no acceptance expected one"); end
      else if (acc_q[n].idx !== 2'd2 || acc_q[n].data !== 18'h2_AAAA)
         begin errors++; $display("FAIL hold_resend: got %0d/%h expected 2/2aaaa", acc_q[n].idx, acc_q[n].data); end
      mode = 2'b11;
      n = acc_q.size();
      wr_en = 1'b1; wr_idx = 2'd1; wr_data = 18'h1_5555;
      tick();
      wr_en = 1'b0;
      repeat (20) tick();
      checks++;
      if (acc_q.size() != n) begin errors++; $display("FAIL hold_other_slot: got %0d acceptances expected %0d", acc_q.size(), n); end
   endtask

   task automatic test_write_in_send();
      bit ok;
      int n;
      mode = MODE_MANUAL;
      for (int j = 0; j < 2; j++) begin
         step_accept(ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL wsend_walk%0d: got no acceptance expected one", j); end
      end
      ready = 1'b0;
      pulse_step();
      wait_valid(20, ok);
      checks++;
      if (!ok || o_msg_idx !== 2'd1 || o_msg_data !== 18'h1_5555)
         begin errors++; $display("FAIL wsend_start: got %b/%0d/%h expected 1/1/15555", ok, o_msg_idx, o_msg_data); end
      wr_en = 1'b1; wr_idx = 2'd1; wr_data = 18'h0_F0F0;
      tick();
      wr_en = 1'b0;
      tick();
      checks++;
      if ({o_msg_valid, o_msg_data} !== {1'b1, 18'h1_5555})
         begin errors++; $display("FAIL wsend_stable: got %b/%h expected 1/15555", o_msg_valid, o_msg_data); end
      n = acc_q.size();
      ready = 1'b1;
      wait_accept(n + 1, 10, ok);
      checks++;
      if (!ok || acc_q[acc_q.size()-1].data !== 18'h1_5555)
         begin errors++; $display("FAIL wsend_old: got %b/%h expected 1/15555", ok, acc_q[acc_q.size()-1].data); end
      for (int j = 0; j < 4; j++) step_accept(ok);
      checks++;
      if (!ok || acc_q[acc_q.size()-1].idx !== 2'd1 || acc_q[acc_q.size()-1].data !== 18'h0_F0F0)
         begin errors++; $display("FAIL wsend_new: got %b/%0d/%h expected 1/1/0f0f0", ok, acc_q[acc_q.size()-1].idx, acc_q[acc_q.size()-1].data); end
   endtask

   task automatic test_reset_midway();
      bit ok;
      int n;
      ready = 1'b0;
      pulse_step();
      wait_valid(20, ok);
      checks++;
      if (!ok || o_msg_idx !== 2'd2) begin errors++; $display("FAIL rsend_setup: got %b/%0d expected 1/2", ok, o_msg_idx); end
      rst = 1'b1;
      tick();
      checks++;
      if ({o_msg_valid, o_msg_idx, o_msg_data, o_leds} !== 31'h0)
         begin errors++; $display("FAIL rsend_clear: got %b/%0d/%h/%h expected 0/0/0/0", o_msg_valid, o_msg_idx, o_msg_data, o_leds); end
      rst = 1'b0;
      tick();
      checks++;
      if (o_msg_valid !== 1'b0) begin errors++; $display("FAIL rsend_early: got %b expected 0", o_msg_valid); end
      tick();
      checks++;
      if ({o_msg_valid, o_msg_idx, o_msg_data} !== {1'b1, 2'd0, 18'h0})
         begin errors++; $display("FAIL rsend_restart: got %b/%0d/%h expected 1/0/0", o_msg_valid, o_msg_idx, o_msg_data); end
      n = acc_q.size();
      ready = 1'b1;
      wait_accept(n + 1, 10, ok);
      step_accept(ok);
      checks++;
      if (!ok || acc_q[acc_q.size()-1].idx !== 2'd1 || acc_q[acc_q.size()-1].data !== 18'h0)
         begin errors++; $display("FAIL rsend_slot1_cleared: got %b/%0d/%h expected 1/1/0", ok, acc_q[acc_q.size()-1].idx, acc_q[acc_q.size()-1].data); end
      rst = 1'b1;
      tick();
      checks++;
      if ({o_msg_valid, o_msg_idx} !== 3'b000)
         begin errors++; $display("FAIL rdwell_clear: got %b/%0d expected 0/0", o_msg_valid, o_msg_idx); end
      rst = 1'b0;
      tick();
      tick();
      checks++;
      if ({o_msg_valid, o_msg_idx} !== {1'b1, 2'd0})
         begin errors++; $display("FAIL rdwell_restart: got %b/%0d expected 1/0", o_msg_valid, o_msg_idx); end
   endtask

   initial begin
      test_reset();
      test_auto_rotate();
      test_ready_stall();
      test_manual_step();
      test_hold_resend();
      test_write_in_send();
      test_reset_midway();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
